// File: rtl/cam_pwr_pkg.sv
// Shared types and 10 MHz default timing for the camera power sequencer.
// State values double as the debug encoding exported on state_o.
package cam_pwr_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_PWR_WAIT = 3'd1,
    ST_PWDN_LOW = 3'd2,
    ST_RST_HIGH = 3'd3,
    ST_INIT     = 3'd4,
    ST_READY    = 3'd5,
    ST_RECOVER  = 3'd6,
    ST_SHUTDOWN = 3'd7
  } cam_state_e;

  // Delays in 10 MHz cycles: ~5 ms, 1.3 ms, 21 ms, ~100 us
  localparam int unsigned DEF_T_PWDN    = 53248;
  localparam int unsigned DEF_T_RST     = 13107;
  localparam int unsigned DEF_T_INIT    = 209715;
  localparam int unsigned DEF_T_OFF     = 1024;
  localparam int unsigned DEF_MAX_RETRY = 3;
  localparam int unsigned DEF_CNT_W     = 18;

  function automatic int unsigned retry_w(input int unsigned max_retry);
    return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
  endfunction

  localparam int unsigned DEF_RETRY_W = retry_w(DEF_MAX_RETRY);

endpackage

// File: rtl/cam_power_seq.sv
// Power-up / shutdown / retry sequencer for NUM_CAM sensors sharing one timer.
// Next state and next pin values are decoded combinationally, then registered together.
module cam_power_seq
  import cam_pwr_pkg::*;
#(
  parameter int unsigned NUM_CAM   = 2,
  parameter int unsigned T_PWDN    = DEF_T_PWDN,
  parameter int unsigned T_RST     = DEF_T_RST,
  parameter int unsigned T_INIT    = DEF_T_INIT,
  parameter int unsigned T_OFF     = DEF_T_OFF,
  parameter int unsigned MAX_RETRY = DEF_MAX_RETRY,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic               clk_10M,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_CAM-1:0] cam_en,
  input  logic               init_done,
  input  logic               init_fail,
  output logic [NUM_CAM-1:0] cam_pwdn,
  output logic [NUM_CAM-1:0] cam_rstn,
  output logic               initial_en,
  output logic               ready,
  output logic               fault,
  output logic [2:0]         state_o
);

  localparam int unsigned RETRY_W = retry_w(MAX_RETRY);

  localparam logic [CNT_W-1:0]   PWDN_LAST = CNT_W'(T_PWDN - 1);
  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(T_RST - 1);
  localparam logic [CNT_W-1:0]   INIT_LAST = CNT_W'(T_INIT - 1);
  localparam logic [CNT_W-1:0]   OFF_LAST  = CNT_W'(T_OFF - 1);
  localparam logic [CNT_W-1:0]   TIMER_MAX = '1;
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  cam_state_e         state, state_nxt;
  logic [CNT_W-1:0]   timer;
  logic [RETRY_W-1:0] retry_cnt;
  logic [NUM_CAM-1:0] en_mask;
  logic               go_fault;
  logic [NUM_CAM-1:0] pwdn_nxt, rstn_nxt;

  // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    go_fault  = 1'b0;
    if (state != ST_OFF && state != ST_SHUTDOWN && !enable) begin
      state_nxt = ST_SHUTDOWN;
    end else begin
      case (state)
        ST_OFF:      if (enable && !fault) state_nxt = ST_PWR_WAIT;
        ST_PWR_WAIT: if (timer == PWDN_LAST) state_nxt = ST_PWDN_LOW;
        ST_PWDN_LOW: if (timer == RST_LAST) state_nxt = ST_RST_HIGH;
        ST_RST_HIGH: if (timer == INIT_LAST) state_nxt = ST_INIT;
        ST_INIT: begin
          // A failure outranks a simultaneous success
          if (init_fail) begin
            if (retry_cnt >= RETRY_MAX) begin
              state_nxt = ST_OFF;
              go_fault  = 1'b1;
            end else begin
              state_nxt = ST_RECOVER;
            end
          end else if (init_done) begin
            state_nxt = ST_READY;
          end
        end
        ST_READY:    state_nxt = ST_READY;
        ST_RECOVER:  if (timer == OFF_LAST) state_nxt = ST_PWR_WAIT;
        ST_SHUTDOWN: if (timer == OFF_LAST) state_nxt = ST_OFF;
      endcase
    end

    // Pins follow the state being entered; masked sensors stay powered down in reset
    pwdn_nxt = '1;
    rstn_nxt = '0;
    case (state_nxt)
      ST_PWDN_LOW, ST_RECOVER, ST_SHUTDOWN: pwdn_nxt = ~en_mask;
      ST_RST_HIGH, ST_INIT, ST_READY: begin
        pwdn_nxt = ~en_mask;
        rstn_nxt = en_mask;
      end
      default: ;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_10M or posedge reset) begin
    if (reset) begin
      state      <= ST_OFF;
      timer      <= '0;
      retry_cnt  <= '0;
      en_mask    <= '0;
      fault      <= 1'b0;
      cam_pwdn   <= '1;
      cam_rstn   <= '0;
      initial_en <= 1'b0;
      ready      <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state)     timer <= '0;
      else if (timer != TIMER_MAX) timer <= timer + 1'b1;

      if (state == ST_OFF) begin
        retry_cnt <= '0;
        if (!enable)    fault   <= 1'b0;
        else if (!fault) en_mask <= cam_en;
      end
      if (state == ST_INIT && state_nxt == ST_RECOVER) retry_cnt <= retry_cnt + 1'b1;
      if (go_fault) fault <= 1'b1;

      cam_pwdn   <= pwdn_nxt;
      cam_rstn   <= rstn_nxt;
      initial_en <= (state_nxt == ST_INIT);
      ready      <= (state_nxt == ST_READY);
    end
  end

  assign state_o = state;

endmodule
